// File: rtl/lfsr_ctrl_pkg.sv
// Shared types and default sizes for the LFSR sequence controller.
// The state enumeration lives here so that related blocks decode it consistently.
package lfsr_ctrl_pkg;

  localparam int N_DEF     = 8;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage : lfsr_ctrl_pkg

// File: rtl/lfsr_seq_ctrl.sv
// Sequencer for an external serial-load LFSR: clear it, shift a seed in MSB
// first, then pass run_len generated bits through with a valid strobe.
module lfsr_seq_ctrl
  import lfsr_ctrl_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [N-1:0]     seed,
  input  logic [CNT_W-1:0] run_len,
  input  logic             lfsr_out,
  output logic             lfsr_reset,
  output logic             lfsr_load,
  output logic             lfsr_s_in,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int               CW      = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]    LD_LAST = CW'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [N-1:0]     seed_q, seed_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CW-1:0]    ld_cnt_q, ld_cnt_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic             err_d;

  logic             clear_q, clear_d;
  logic             load_q, load_d;
  logic             s_in_q, s_in_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q;
  logic [CW-1:0]    ld_idx;

  // Next-state, capture and counter logic.
  always_comb begin
    state_d   = state_q;
    seed_d    = seed_q;
    len_d     = len_q;
    ld_cnt_d  = ld_cnt_q;
    run_cnt_d = run_cnt_q;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Start wins over abort here; a zero seed would lock the XOR feedback.
        if (start) begin
          if (seed != {N{1'b0}}) begin
            seed_d  = seed;
            len_d   = run_len;
            state_d = ST_CLEAR;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          state_d  = ST_LOAD;
          ld_cnt_d = {CW{1'b0}};
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (ld_cnt_q == LD_LAST) begin
          ld_cnt_d = {CW{1'b0}};
          if (len_q != {CNT_W{1'b0}}) begin
            state_d   = ST_RUN;
            run_cnt_d = len_q;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          ld_cnt_d = ld_cnt_q + CW'(1);
        end
      end
      ST_RUN: begin
        // Down-counter exits at 1, so an all-ones length never wraps.
        if (abort) begin
          state_d   = ST_IDLE;
          run_cnt_d = {CNT_W{1'b0}};
        end else if (run_cnt_q == CNT_ONE) begin
          state_d   = ST_DONE;
          run_cnt_d = {CNT_W{1'b0}};
        end else begin
          run_cnt_d = run_cnt_q - CNT_ONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    ld_idx  = LD_LAST - ld_cnt_d;
    clear_d = (state_d == ST_CLEAR);
    load_d  = (state_d == ST_LOAD);
    s_in_d  = load_d & seed_d[ld_idx];
    valid_d = (state_d == ST_RUN);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  // State, captured operands, counters and registered control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      seed_q    <= {N{1'b0}};
      len_q     <= {CNT_W{1'b0}};
      ld_cnt_q  <= {CW{1'b0}};
      run_cnt_q <= {CNT_W{1'b0}};
      clear_q   <= 1'b0;
      load_q    <= 1'b0;
      s_in_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      seed_q    <= seed_d;
      len_q     <= len_d;
      ld_cnt_q  <= ld_cnt_d;
      run_cnt_q <= run_cnt_d;
      clear_q   <= clear_d;
      load_q    <= load_d;
      s_in_q    <= s_in_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // While reset is held the LFSR is kept in reset and everything else is quiet.
  assign lfsr_reset = reset | clear_q;
  assign lfsr_load  = load_q & ~reset;
  assign lfsr_s_in  = s_in_q & ~reset;
  assign bit_valid  = valid_q & ~reset;
  assign bit_out    = valid_q & ~reset & lfsr_out;
  assign busy       = busy_q & ~reset;
  assign done       = done_q & ~reset;
  assign err        = err_q & ~reset;

endmodule : lfsr_seq_ctrl
